// File: rtl/clk_div_sched.sv
// clk_div_sched: run-time programmable clock divider controller.
// Accepts divide ratios over a valid/ready port. A ratio that arrives
// mid-period is held and applied only at the next period boundary, so
// clk_out never shows a runt pulse. Start and stop also happen only at
// period boundaries.
module clk_div_sched #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cur_div
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [CNT_W-1:0] C_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_DEF  = CNT_W'(DEF_DIV);

  // Length of the high phase for ratio n: ceil(n/2).
  function automatic logic [CNT_W-1:0] f_high_len(input logic [CNT_W-1:0] n);
    f_high_len = n - (n >> 1);
  endfunction

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cur_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_cfg_err;
  logic             r_busy;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cur_div_nxt;
  logic [CNT_W-1:0] w_pend_div_nxt;
  logic             w_clk_out_nxt;
  logic             w_tick_nxt;
  logic             w_cfg_err_nxt;
  logic             w_busy_nxt;

  logic             w_accept;
  logic             w_div_ok;
  logic             w_take;
  logic             w_cfg_bad;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_inc;

  // cfg_ready is a pure decode of the registered state.
  assign o_cfg_ready = (r_state != ST_PEND);

  assign w_accept  = i_cfg_valid & o_cfg_ready;
  assign w_div_ok  = (i_cfg_div >= C_TWO);
  assign w_take    = w_accept & w_div_ok;
  assign w_cfg_bad = w_accept & ~w_div_ok;
  // ">=" rather than "==" so a corrupted counter still closes the period.
  assign w_last    = (r_cnt >= (r_cur_div - C_ONE));
  assign w_cnt_inc = r_cnt + C_ONE;

  // Next-state decode: start/stop and ratio switches only at period boundaries.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cur_div_nxt  = r_cur_div;
    w_pend_div_nxt = r_pend_div;
    w_clk_out_nxt  = r_clk_out;
    w_tick_nxt     = 1'b0;
    w_cfg_err_nxt  = w_cfg_bad;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt      = C_ZERO;
        w_pend_div_nxt = C_ZERO;
        if (w_take) begin
          w_cur_div_nxt = i_cfg_div;
        end else begin
          w_cur_div_nxt = r_cur_div;
        end
        if (i_en) begin
          w_state_nxt   = ST_RUN;
          w_clk_out_nxt = 1'b1;
          w_tick_nxt    = 1'b1;
        end else begin
          w_state_nxt   = ST_IDLE;
          w_clk_out_nxt = 1'b0;
        end
      end
      ST_RUN, ST_PEND: begin
        if (w_last) begin
          // Boundary: a held ratio wins; otherwise a ratio offered right now
          // applies directly to the period that starts at this edge.
          if (r_state == ST_PEND) begin
            w_cur_div_nxt = r_pend_div;
          end else if (w_take) begin
            w_cur_div_nxt = i_cfg_div;
          end else begin
            w_cur_div_nxt = r_cur_div;
          end
          w_pend_div_nxt = C_ZERO;
          w_cnt_nxt      = C_ZERO;
          if (i_en) begin
            w_state_nxt   = ST_RUN;
            w_clk_out_nxt = 1'b1;
            w_tick_nxt    = 1'b1;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_clk_out_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt     = w_cnt_inc;
          w_clk_out_nxt = (w_cnt_inc < f_high_len(r_cur_div));
          if (w_take) begin
            w_state_nxt    = ST_PEND;
            w_pend_div_nxt = i_cfg_div;
          end else begin
            w_state_nxt    = r_state;
            w_pend_div_nxt = r_pend_div;
          end
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_cnt_nxt      = C_ZERO;
        w_cur_div_nxt  = C_DEF;
        w_pend_div_nxt = C_ZERO;
        w_clk_out_nxt  = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= C_ZERO;
      r_cur_div  <= C_DEF;
      r_pend_div <= C_ZERO;
      r_clk_out  <= 1'b0;
      r_tick     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur_div  <= w_cur_div_nxt;
      r_pend_div <= w_pend_div_nxt;
      r_clk_out  <= w_clk_out_nxt;
      r_tick     <= w_tick_nxt;
      r_cfg_err  <= w_cfg_err_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign o_cfg_err = r_cfg_err;
  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_busy    = r_busy;
  assign o_cur_div = r_cur_div;

endmodule

// File: tb/tb_clk_div_sched.sv
// Testbench for clk_div_sched: directed scenarios plus random stimulus,
// every cycle compared against a period-level reference model.
`timescale 1ns/1ps
module tb_clk_div_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, cfg_err, clk_out, tick, busy;
  logic [7:0] cur_div;

  clk_div_sched #(.CNT_W(8), .DEF_DIV(2)) dut (
    .clk(clk), .rstn(rstn), .i_en(en), .i_cfg_valid(cfg_valid),
    .i_cfg_div(cfg_div), .o_cfg_ready(cfg_ready), .o_cfg_err(cfg_err),
    .o_clk_out(clk_out), .o_tick(tick), .o_busy(busy), .o_cur_div(cur_div)
  );

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {clk_out, tick, busy, cfg_ready, cfg_err, cur_div};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: running flag, position inside the period, ratio in
  // effect, and a queue of ratios waiting for the next boundary.
  bit          m_run;
  int          m_pos;
  int          m_div;
  int          m_q[$];
  bit          m_tick;
  bit          m_err;
  logic [12:0] m_exp;

  function automatic logic [12:0] model_outputs();
    logic hi;
    logic [7:0] dv;
    hi = m_run && (m_pos < (m_div + 1) / 2);
    dv = m_div[7:0];
    return {hi, m_tick, m_run, (m_q.size() == 0), m_err, dv};
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0; m_div = 2; m_q.delete();
    m_tick = 1'b0; m_err = 1'b0;
    m_exp = model_outputs();
  endtask

  task automatic model_step(input bit e, input bit v, input int d);
    bit acc;
    acc    = v && (m_q.size() == 0);
    m_err  = acc && (d < 2);
    m_tick = 1'b0;
    if (!m_run) begin
      if (acc && d >= 2) m_div = d;
      if (e) begin m_run = 1'b1; m_pos = 0; m_tick = 1'b1; end
    end else if (m_pos == m_div - 1) begin
      if (m_q.size() > 0) m_div = m_q.pop_front();
      else if (acc && d >= 2) m_div = d;
      m_pos = 0;
      if (e) m_tick = 1'b1;
      else   m_run = 1'b0;
    end else begin
      m_pos++;
      if (acc && d >= 2) m_q.push_back(d);
    end
    m_exp = model_outputs();
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic drive(input bit e, input bit v, input int d);
    en = e; cfg_valid = v; cfg_div = d[7:0];
    @(posedge clk);
    model_step(e, v, d);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (obs !== m_exp) begin n_fail++; $display("FAIL reset_init got %b want %b", obs, m_exp); end
    rstn = 1'b1;
    drive(1'b0, 1'b1, 5);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 0);
      n_tests++;
      if (obs !== m_exp) begin n_fail++; $display("FAIL reset_prerun cyc %0d got %b want %b", i, obs, m_exp); end
    end
    #3; rstn = 1'b0; #1;
    model_reset();
    n_tests++;
    if (obs !== 13'b0_0_0_1_0_00000010) begin n_fail++; $display("FAIL reset_async got %b want %b", obs, 13'b0_0_0_1_0_00000010); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (tick !== 1'b0 || obs !== m_exp) begin n_fail++; $display("FAIL reset_hold cyc %0d got %b want %b", i, obs, m_exp); end
    end
    en = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_default();
    int nt;
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 0);
      nt += int'(tick);
      n_tests++;
      if (obs !== m_exp || clk_out !== ((i % 2) == 0)) begin
        n_fail++; $display("FAIL default cyc %0d got %b want %b", i, obs, m_exp);
      end
    end
    n_tests++;
    if (nt !== 4) begin n_fail++; $display("FAIL default_ticks got %0d want 4", nt); end
  endtask

  task automatic stop_to_idle(input string tag);
    for (int i = 0; i < 300 && m_run; i++) begin
      drive(1'b0, 1'b0, 0);
      n_tests++;
      if (obs !== m_exp) begin n_fail++; $display("FAIL %s_stop cyc %0d got %b want %b", tag, i, obs, m_exp); end
    end
    n_tests++;
    if (busy !== 1'b0 || m_run) begin n_fail++; $display("FAIL %s_idle_timeout busy %b", tag, busy); end
  endtask

  task automatic test_cfg_idle();
    int nh, nt;
    nh = 0; nt = 0;
    stop_to_idle("cfgidle");
    drive(1'b0, 1'b1, 5);
    n_tests++;
    if (cur_div !== 8'd5 || busy !== 1'b0) begin n_fail++; $display("FAIL cfgidle_div got %0d want 5", cur_div); end
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, 0);
      nh += int'(clk_out); nt += int'(tick);
      n_tests++;
      if (obs !== m_exp) begin n_fail++; $display("FAIL cfgidle_run cyc %0d got %b want %b", i, obs, m_exp); end
    end
    n_tests++;
    if (nh !== 9 || nt !== 3) begin n_fail++; $display("FAIL cfgidle_shape got hi=%0d ticks=%0d want hi=9 ticks=3", nh, nt); end
  endtask

  task automatic test_midperiod();
    int nh;
    nh = 0;
    stop_to_idle("mid");
    drive(1'b0, 1'b1, 4);
    drive(1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    drive(1'b1, 1'b1, 3);
    n_tests++;
    if (cfg_ready !== 1'b0 || cur_div !== 8'd4 || obs !== m_exp) begin
      n_fail++; $display("FAIL mid_accept got %b want %b", obs, m_exp);
    end
    drive(1'b1, 1'b1, 7);
    n_tests++;
    if (cfg_ready !== 1'b0 || cur_div !== 8'd4 || obs !== m_exp) begin
      n_fail++; $display("FAIL mid_holdoff got %b want %b", obs, m_exp);
    end
    drive(1'b1, 1'b0, 0);
    n_tests++;
    if (cfg_ready !== 1'b1 || cur_div !== 8'd3 || tick !== 1'b1 || obs !== m_exp) begin
      n_fail++; $display("FAIL mid_switch got %b want %b", obs, m_exp);
    end
    nh = int'(clk_out);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 0);
      nh += int'(clk_out);
      n_tests++;
      if (obs !== m_exp) begin n_fail++; $display("FAIL mid_after cyc %0d got %b want %b", i, obs, m_exp); end
    end
    n_tests++;
    if (nh !== 4) begin n_fail++; $display("FAIL mid_shape got hi=%0d want 4", nh); end
  endtask

  task automatic test_inv_boundary();
    drive(1'b1, 1'b1, 1);
    n_tests++;
    if (cfg_err !== 1'b1 || cur_div !== 8'd3 || obs !== m_exp) begin
      n_fail++; $display("FAIL inv_err1 got %b want %b", obs, m_exp);
    end
    drive(1'b1, 1'b0, 0);
    n_tests++;
    if (cfg_err !== 1'b0 || obs !== m_exp) begin n_fail++; $display("FAIL inv_errpulse got %b want %b", obs, m_exp); end
    drive(1'b1, 1'b1, 0);
    n_tests++;
    if (cfg_err !== 1'b1 || cur_div !== 8'd3) begin n_fail++; $display("FAIL inv_err0 got %b want %b", obs, m_exp); end
    for (int i = 0; i < 10 && m_pos != m_div - 1; i++) begin
      drive(1'b1, 1'b0, 0);
      n_tests++;
      if (obs !== m_exp) begin n_fail++; $display("FAIL bnd_wait cyc %0d got %b want %b", i, obs, m_exp); end
    end
    drive(1'b1, 1'b1, 6);
    n_tests++;
    if (cur_div !== 8'd6 || cfg_ready !== 1'b1 || tick !== 1'b1 || obs !== m_exp) begin
      n_fail++; $display("FAIL bnd_direct got %b want %b", obs, m_exp);
    end
  endtask

  task automatic test_stop();
    int nc;
    nc = 0;
    for (int i = 0; i < 10 && m_pos != 2; i++) begin
      drive(1'b1, 1'b0, 0);
      n_tests++;
      if (obs !== m_exp) begin n_fail++; $display("FAIL stop_wait cyc %0d got %b want %b", i, obs, m_exp); end
    end
    for (int i = 0; i < 12 && busy; i++) begin
      drive(i == 1, 1'b0, 0);
      nc++;
      n_tests++;
      if (obs !== m_exp) begin n_fail++; $display("FAIL stop_drain cyc %0d got %b want %b", i, obs, m_exp); end
    end
    n_tests++;
    if (nc !== 4 || busy !== 1'b0 || clk_out !== 1'b0) begin
      n_fail++; $display("FAIL stop_latency got %0d cycles busy=%b want 4 busy=0", nc, busy);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 0);
      n_tests++;
      if (clk_out !== 1'b0 || tick !== 1'b0 || obs !== m_exp) begin n_fail++; $display("FAIL stop_idle cyc %0d got %b want %b", i, obs, m_exp); end
    end
    drive(1'b1, 1'b0, 0);
    n_tests++;
    if (tick !== 1'b1 || clk_out !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL stop_restart got %b want %b", obs, m_exp); end
  endtask

  task automatic test_random();
    bit e, v;
    int d;
    for (int i = 0; i < 800; i++) begin
      e = ($urandom_range(0, 11) != 0);
      v = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
      drive(e, v, d);
      n_tests++;
      if (obs !== m_exp) begin n_fail++; $display("FAIL random cyc %0d got %b want %b", i, obs, m_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_cfg_idle();
    test_midperiod();
    test_inv_boundary();
    test_stop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
